dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 22 ++
 rtl/dmem_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: FSM states and requester IDs.
package dmem_pkg;

    typedef enum logic {
        ST_RR     = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } req_id_e;

    // The requester that should be favoured after `id` has been served.
    function automatic req_id_e other_req(input req_id_e id);
        return (id == REQ_CPU) ? REQ_DMA : REQ_CPU;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone request always wins, contention goes
// to the side named by prio. Purely combinational.
module rr_arbiter2
    import dmem_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_e    prio,
    output logic [1:0] gnt
);

    // Select the single winner from the request pair and the priority pointer.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (prio == REQ_CPU) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the CPU and a DMA/loader port.
// Round-robin in normal operation; the DMA can lock the memory for a bounded
// burst of consecutive grants. Read data comes back one cycle after accept.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LOCK_MAX   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // CPU port
    input  logic                  c_valid,
    input  logic                  c_we,
    input  logic [DATA_WIDTH-1:0] c_addr,
    input  logic [DATA_WIDTH-1:0] c_wdata,
    output logic                  c_ready,
    output logic                  c_rvalid,
    output logic [DATA_WIDTH-1:0] c_rdata,
    // DMA / loader port
    input  logic                  d_valid,
    input  logic                  d_we,
    input  logic                  d_lock,
    input  logic [DATA_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ready,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    // Memory port
    output logic [DATA_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0] mem_wd,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rd
);

    localparam int              CNT_W      = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);
    // With a limit of one grant a lock would expire on the very beat that
    // requests it, so the locked state is never entered.
    localparam bit              LOCK_EN    = (LOCK_MAX > 1);

    arb_state_e             state_q, state_d;
    req_id_e                prio_q, prio_d;
    logic [CNT_W-1:0]       lock_cnt_q, lock_cnt_d;
    logic [CNT_W-1:0]       lock_cnt_inc;
    logic                   c_rvalid_q, c_rvalid_d;
    logic                   d_rvalid_q, d_rvalid_d;
    logic [DATA_WIDTH-1:0]  c_rdata_q, c_rdata_d;
    logic [DATA_WIDTH-1:0]  d_rdata_q, d_rdata_d;

    logic [1:0]             arb_gnt;
    logic                   c_acc;
    logic                   d_acc;

    rr_arbiter2 u_rr_arbiter2 (
        .req  ({d_valid, c_valid}),
        .prio (prio_q),
        .gnt  (arb_gnt)
    );

    assign lock_cnt_inc = lock_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    assign c_acc        = c_valid & c_ready;
    assign d_acc        = d_valid & d_ready;

    // Ready generation: locked state serves only the DMA, otherwise the
    // round-robin grant decides; nothing is accepted while in reset.
    always_comb begin
        c_ready = 1'b0;
        d_ready = 1'b0;
        if (rst_n && (state_q == ST_LOCKED)) begin
            d_ready = d_valid;
        end else if (rst_n) begin
            c_ready = arb_gnt[0];
            d_ready = arb_gnt[1];
        end else begin
            c_ready = 1'b0;
            d_ready = 1'b0;
        end
    end

    // Steer the accepted request onto the memory port; no write when idle.
    always_comb begin
        mem_a  = c_addr;
        mem_wd = c_wdata;
        mem_we = 1'b0;
        if (d_acc) begin
            mem_a  = d_addr;
            mem_wd = d_wdata;
            mem_we = d_we;
        end else if (c_acc) begin
            mem_a  = c_addr;
            mem_wd = c_wdata;
            mem_we = c_we;
        end else begin
            mem_we = 1'b0;
        end
    end

    // Next-state logic: read capture, priority rotation and the lock FSM.
    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        lock_cnt_d = lock_cnt_q;
        c_rvalid_d = c_acc & ~c_we;
        d_rvalid_d = d_acc & ~d_we;
        c_rdata_d  = c_rdata_q;
        d_rdata_d  = d_rdata_q;

        if (c_acc && !c_we) begin
            c_rdata_d = mem_rd;
        end else begin
            c_rdata_d = c_rdata_q;
        end

        if (d_acc && !d_we) begin
            d_rdata_d = mem_rd;
        end else begin
            d_rdata_d = d_rdata_q;
        end

        if (c_acc || d_acc) begin
            prio_d = other_req(d_acc ? REQ_DMA : REQ_CPU);
        end else begin
            prio_d = prio_q;
        end

        case (state_q)
            ST_RR: begin
                lock_cnt_d = {CNT_W{1'b0}};
                if (LOCK_EN && d_acc && d_lock) begin
                    // The beat that takes the lock is the first of the burst.
                    state_d    = ST_LOCKED;
                    lock_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    state_d = ST_RR;
                end
            end
            ST_LOCKED: begin
                if (!d_valid || !d_lock || (lock_cnt_inc >= LOCK_MAX_C)) begin
                    // Any exit hands the next contention to the CPU.
                    state_d    = ST_RR;
                    lock_cnt_d = {CNT_W{1'b0}};
                    prio_d     = REQ_CPU;
                end else begin
                    lock_cnt_d = lock_cnt_inc;
                end
            end
            default: begin
                state_d    = ST_RR;
                lock_cnt_d = {CNT_W{1'b0}};
                prio_d     = REQ_CPU;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RR;
            prio_q     <= REQ_CPU;
            lock_cnt_q <= {CNT_W{1'b0}};
            c_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            c_rdata_q  <= {DATA_WIDTH{1'b0}};
            d_rdata_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            lock_cnt_q <= lock_cnt_d;
            c_rvalid_q <= c_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            c_rdata_q  <= c_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign c_rvalid = c_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign c_rdata  = c_rdata_q;
    assign d_rdata  = d_rdata_q;

endmodule
